// File: rtl/rr_shi_out_256.sv
// ---------------------------------------------------------------------------
// rr_shi_out_256
//   Word-serial unloader for a 256-bit operand register. A result is
//   parallel-loaded, optionally doubled one bit at a time (the MSB falls
//   into carry_out), then streamed out least-significant word first as
//   NWORDS words of WORD_W bits under a valid/ready handshake. The words
//   leave in the same order the word loader consumes them, so a result can
//   be fed straight back into the datapath.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous reset, active-high
//   load        parallel load of din into the register (IDLE only)
//   din         parallel load data
//   shl         left shift of the register by one bit (IDLE only)
//   start       begin streaming NWORDS words (IDLE only)
//   dout        current word = register[WORD_W-1:0]
//   dout_valid  dout holds a word to transfer
//   dout_ready  downstream accepts dout
//   busy        high while streaming
//   done        one-cycle pulse after the last word transfers
//   carry_out   bit shifted out of the MSB by the most recent shl
//   regout      live register contents
// ---------------------------------------------------------------------------
module rr_shi_out_256 #(
  parameter int WORD_W = 16,
  parameter int NWORDS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [WORD_W*NWORDS-1:0]   din,
  input  logic                       shl,
  input  logic                       start,
  output logic [WORD_W-1:0]          dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       carry_out,
  output logic [WORD_W*NWORDS-1:0]   regout
);

  localparam int REG_W = WORD_W * NWORDS;
  localparam int CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [REG_W-1:0]     reg_q, reg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 carry_q, carry_d;
  logic                 done_q, done_d;
  logic                 xfer;

  // Doubling: shift left by one, zero fills the LSB.
  function automatic logic [REG_W-1:0] dbl(input logic [REG_W-1:0] v);
    return {v[REG_W-2:0], 1'b0};
  endfunction

  // Moves the next word into the dout position while keeping every bit,
  // so a full stream leaves the register exactly as it was loaded.
  function automatic logic [REG_W-1:0] rot_word(input logic [REG_W-1:0] v);
    return {v[WORD_W-1:0], v[REG_W-1:WORD_W]};
  endfunction

  assign xfer = (state_q == SEND) && dout_ready;

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // One action per cycle; lower-priority requests are dropped.
        if (load) begin
          reg_d   = din;
          carry_d = 1'b0;
        end else if (shl) begin
          reg_d   = dbl(reg_q);
          carry_d = reg_q[REG_W-1];
        end else if (start) begin
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          reg_d = rot_word(reg_q);
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register stage: reset clears the operand register as well, so an
  // aborted stream never leaves a partially rotated value behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      reg_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign dout       = reg_q[WORD_W-1:0];
  assign dout_valid = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign done       = done_q;
  assign carry_out  = carry_q;
  assign regout     = reg_q;

endmodule

// File: tb/tb_rr_shi_out_256.sv
module tb_rr_shi_out_256;

  logic         clk = 1'b0;
  logic         rst, load, shl, start, dout_ready;
  logic [255:0] din;
  logic [15:0]  dout;
  logic         dout_valid, busy, done, carry_out;
  logic [255:0] regout;

  int n_cmp = 0;
  int n_bad = 0;

  rr_shi_out_256 #(.WORD_W(16), .NWORDS(16)) dut (
    .clk(clk), .rst(rst), .load(load), .din(din), .shl(shl), .start(start),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .done(done), .carry_out(carry_out), .regout(regout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic         rst, load, shl, start, ready;
    logic [255:0] din;
    logic [255:0] exp_reg;
    logic         exp_carry, exp_busy;
  } vec_t;

  function automatic vec_t mk(logic r, logic l, logic s, logic st, logic rd,
                              logic [255:0] d, logic [255:0] er,
                              logic ec, logic eb);
    vec_t v;
    v.rst = r; v.load = l; v.shl = s; v.start = st; v.ready = rd;
    v.din = d; v.exp_reg = er; v.exp_carry = ec; v.exp_busy = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; load = 1'b0; shl = 1'b0; start = 1'b0;
  endtask

  // Loads a 0x1000+i pattern, starts, and checks all 16 words.
  // bp: ready alternates 0/1 starting at 0. ign: pulse load/shl/start mid-stream.
  task automatic run_stream(input bit bp, input bit ign, input string tag);
    logic [255:0] exp_din;
    int k;
    for (int i = 0; i < 16; i++) exp_din[16*i +: 16] = 16'h1000 + 16'(i);
    idle_inputs();
    din = exp_din; load = 1'b1; step();
    load = 1'b0; din = '1; start = 1'b1; dout_ready = 1'b0; step();
    start = 1'b0;
    k = 0;
    for (int c = 0; c < (bp ? 32 : 16); c++) begin
      chk({tag, " dout"}, {240'b0, dout}, {240'b0, 16'h1000 + 16'(k)});
      chk({tag, " valid"}, {255'b0, dout_valid}, 256'd1);
      chk({tag, " done_mid"}, {255'b0, done}, 256'd0);
      dout_ready = bp ? logic'(c % 2) : 1'b1;
      if (ign) begin
        load  = (c == 3);
        shl   = (c == 5);
        start = (c == 7);
      end
      step();
      idle_inputs();
      if (dout_ready) k++;
    end
    dout_ready = 1'b0;
    chk({tag, " count"}, 256'(k), 256'd16);
    chk({tag, " done"}, {255'b0, done}, 256'd1);
    chk({tag, " busy_end"}, {255'b0, busy}, 256'd0);
    chk({tag, " valid_end"}, {255'b0, dout_valid}, 256'd0);
    chk({tag, " regout"}, regout, exp_din);
    step();
    chk({tag, " done_once"}, {255'b0, done}, 256'd0);
  endtask

  vec_t vt[14];
  logic [255:0] a_val;

  initial begin
    idle_inputs();
    dout_ready = 1'b0;
    din = '0;
    rst = 1'b1; step(); step();
    rst = 1'b0;
    chk("rst regout", regout, 256'd0);
    chk("rst dout", {240'b0, dout}, 256'd0);
    chk("rst valid", {255'b0, dout_valid}, 256'd0);
    chk("rst busy", {255'b0, busy}, 256'd0);
    chk("rst done", {255'b0, done}, 256'd0);
    chk("rst carry", {255'b0, carry_out}, 256'd0);

    // Shift, carry and priority table
    a_val = {16'h8000, 224'h0, 16'h0001};
    //             rst load shl start rdy din              exp_reg              c  busy
    vt[0]  = mk(1, 0, 0, 0, 0, 256'hDEAD,  256'h0,              0, 0);
    vt[1]  = mk(0, 1, 0, 0, 0, a_val,      a_val,               0, 0);
    vt[2]  = mk(0, 0, 1, 0, 0, 256'hDEAD,  256'h2,              1, 0);
    vt[3]  = mk(0, 0, 0, 0, 0, 256'hDEAD,  256'h2,              1, 0);
    vt[4]  = mk(0, 0, 1, 0, 0, 256'hDEAD,  256'h4,              0, 0);
    vt[5]  = mk(0, 1, 0, 0, 0, a_val,      a_val,               0, 0);
    vt[6]  = mk(0, 0, 1, 0, 0, 256'hDEAD,  256'h2,              1, 0);
    vt[7]  = mk(0, 1, 0, 0, 0, 256'h123,   256'h123,            0, 0);
    vt[8]  = mk(0, 1, 1, 1, 0, 256'h5,     256'h5,              0, 0);
    vt[9]  = mk(0, 0, 1, 1, 0, 256'hDEAD,  256'hA,              0, 0);
    vt[10] = mk(0, 0, 0, 1, 0, 256'hDEAD,  256'hA,              0, 1);
    vt[11] = mk(0, 0, 0, 0, 0, 256'hDEAD,  256'hA,              0, 1);
    vt[12] = mk(0, 0, 0, 0, 1, 256'hDEAD,  256'hA << 240,       0, 1);
    vt[13] = mk(1, 0, 0, 0, 1, 256'hDEAD,  256'h0,              0, 0);

    for (int i = 0; i < 14; i++) begin
      rst = vt[i].rst; load = vt[i].load; shl = vt[i].shl;
      start = vt[i].start; dout_ready = vt[i].ready; din = vt[i].din;
      step();
      chk($sformatf("vec%0d regout", i), regout, vt[i].exp_reg);
      chk($sformatf("vec%0d dout", i), {240'b0, dout}, {240'b0, vt[i].exp_reg[15:0]});
      chk($sformatf("vec%0d carry", i), {255'b0, carry_out}, {255'b0, vt[i].exp_carry});
      chk($sformatf("vec%0d busy", i), {255'b0, busy}, {255'b0, vt[i].exp_busy});
      chk($sformatf("vec%0d valid", i), {255'b0, dout_valid}, {255'b0, vt[i].exp_busy});
      chk($sformatf("vec%0d done", i), {255'b0, done}, 256'd0);
    end
    idle_inputs();
    dout_ready = 1'b0;

    run_stream(1'b0, 1'b0, "stream");
    run_stream(1'b1, 1'b0, "backpr");
    run_stream(1'b0, 1'b1, "ignore");

    // Abort after the 5th transfer
    for (int i = 0; i < 16; i++) din[16*i +: 16] = 16'h2000 + 16'(i);
    load = 1'b1; step();
    load = 1'b0; start = 1'b1; step();
    start = 1'b0; dout_ready = 1'b1;
    for (int c = 0; c < 5; c++) step();
    chk("abort dout5", {240'b0, dout}, 256'h2005);
    rst = 1'b1; step();
    rst = 1'b0; dout_ready = 1'b0;
    chk("abort valid", {255'b0, dout_valid}, 256'd0);
    chk("abort busy", {255'b0, busy}, 256'd0);
    chk("abort regout", regout, 256'd0);
    chk("abort done", {255'b0, done}, 256'd0);
    step();
    chk("abort done2", {255'b0, done}, 256'd0);

    run_stream(1'b0, 1'b0, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
